// File: rtl/vga_pkg.sv
// 640x480p60 timing constants and shared helpers for the VGA timing block.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_CW       = 10;
  localparam bit VGA_SYNC_POL = 1'b0;

  typedef logic [VGA_CW-1:0] coord_t;

  function automatic logic in_span(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with a configurable reset value; used to
// retime de/hsync/vsync behind the pixel coordinates.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stg <= {DEPTH{RST_VAL}};
    end else if (en) begin
      stg[0] <= din;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign dout = stg[DEPTH-1];

endmodule

// File: rtl/vga_timing_480p.sv
// 640x480p60 display timing generator. Define VGA_TIMING_PIPE_EN to delay
// de/hsync/vsync by PIPE_LAT enabled cycles behind sx/sy/line/frame.
module vga_timing_480p
  import vga_pkg::*;
#(
`ifdef VGA_TIMING_PIPE_EN
  parameter int PIPE_LAT = 2,
`endif
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = VGA_SYNC_POL,
  parameter int CW       = VGA_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line,
  output logic          frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int VS_LO   = V_ACTIVE + V_FP;

  logic [CW-1:0] sx_nxt, sy_nxt;
  logic          h_wrap, de_nxt, hs_nxt, vs_nxt;
  logic          de_q, hs_q, vs_q;

  // Decode from the next coordinates so registered outputs line up with sx/sy.
  always_comb begin
    h_wrap = (sx == CW'(H_TOTAL - 1));
    sx_nxt = h_wrap ? '0 : sx + CW'(1);
    sy_nxt = sy;
    if (h_wrap) sy_nxt = (sy == CW'(V_TOTAL - 1)) ? '0 : sy + CW'(1);
    de_nxt = in_span(int'(sx_nxt), 0, H_ACTIVE - 1) && in_span(int'(sy_nxt), 0, V_ACTIVE - 1);
    hs_nxt = in_span(int'(sx_nxt), HS_LO, HS_LO + H_SYNC - 1) ? SYNC_POL : ~SYNC_POL;
    vs_nxt = in_span(int'(sy_nxt), VS_LO, VS_LO + V_SYNC - 1) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sx    <= CW'(H_TOTAL - 1);
      sy    <= CW'(V_TOTAL - 1);
      de_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      line  <= 1'b0;
      frame <= 1'b0;
    end else if (en) begin
      sx    <= sx_nxt;
      sy    <= sy_nxt;
      de_q  <= de_nxt;
      hs_q  <= hs_nxt;
      vs_q  <= vs_nxt;
      line  <= (sx_nxt == '0);
      frame <= (sx_nxt == '0) && (sy_nxt == '0);
    end else begin
      line  <= 1'b0;
      frame <= 1'b0;
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE_LAT),
    .RST_VAL({1'b0, ~SYNC_POL, ~SYNC_POL})
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .din  ({de_q, hs_q, vs_q}),
    .dout ({de, hsync, vsync})
  );
`else
  assign de    = de_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_480p.sv
// Scoreboard bench: a full-size 480p instance plus a shrunken-timing instance
// so vsync, frame wrap and frame period are reachable in a short run.
module tb_vga_timing_480p;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic       de, hs, vs, line, frame;
  } obs_t;

  logic clk = 1'b0, reset = 1'b1, en = 1'b0;
  always #20 clk = ~clk;

  logic [9:0] sx0, sy0, sx1, sy1;
  logic       de0, hs0, vs0, ln0, fr0, de1, hs1, vs1, ln1, fr1;

  vga_timing_480p dut_big (
    .clk(clk), .reset(reset), .en(en), .sx(sx0), .sy(sy0), .de(de0),
    .hsync(hs0), .vsync(vs0), .line(ln0), .frame(fr0)
  );

  vga_timing_480p #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_small (
    .clk(clk), .reset(reset), .en(en), .sx(sx1), .sy(sy1), .de(de1),
    .hsync(hs1), .vsync(vs1), .line(ln1), .frame(fr1)
  );

  int HA [2] = '{640, 8};
  int HF [2] = '{16, 2};
  int HS [2] = '{96, 3};
  int VA [2] = '{480, 6};
  int VF [2] = '{10, 2};
  int VS [2] = '{2, 2};
  int HT [2] = '{800, 16};
  int VT [2] = '{525, 13};

  int         msx [2];
  int         msy [2];
  logic [2:0] dly [2][2];
  obs_t       sbq [2][$];
  obs_t       got [2];
  int         n_cmp = 0, n_err = 0;

  assign got[0] = {sx0, sy0, de0, hs0, vs0, ln0, fr0};
  assign got[1] = {sx1, sy1, de1, hs1, vs1, ln1, fr1};

  // {de, hsync, vsync} for coordinate (x,y) with negative-polarity sync
  function automatic logic [2:0] dec3(input int k, input int x, input int y);
    logic d, h, v;
    d = (x < HA[k]) && (y < VA[k]);
    h = !((x >= HA[k] + HF[k]) && (x < HA[k] + HF[k] + HS[k]));
    v = !((y >= VA[k] + VF[k]) && (y < VA[k] + VF[k] + VS[k]));
    return {d, h, v};
  endfunction

  // Apply one cycle of stimulus, push the expected post-edge outputs, wait for the edge.
  task automatic drive(input logic r, input logic e);
    obs_t       x;
    logic [2:0] d;
    reset = r;
    en    = e;
    for (int k = 0; k < 2; k++) begin
      d = dec3(k, msx[k], msy[k]);
      if (r) begin
        msx[k] = HT[k] - 1;
        msy[k] = VT[k] - 1;
        dly[k][0] = 3'b011;
        dly[k][1] = 3'b011;
      end else if (e) begin
        dly[k][1] = dly[k][0];
        dly[k][0] = d;
        if (msx[k] == HT[k] - 1) begin
          msx[k] = 0;
          msy[k] = (msy[k] == VT[k] - 1) ? 0 : msy[k] + 1;
        end else begin
          msx[k] = msx[k] + 1;
        end
      end
      x.sx = 10'(msx[k]);
      x.sy = 10'(msy[k]);
`ifdef VGA_TIMING_PIPE_EN
      {x.de, x.hs, x.vs} = dly[k][1];
`else
      {x.de, x.hs, x.vs} = dec3(k, msx[k], msy[k]);
`endif
      x.line  = !r && e && (msx[k] == 0);
      x.frame = x.line && (msy[k] == 0);
      sbq[k].push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t ex;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
        ex = sbq[k].pop_front();
        n_cmp++;
        if (got[k] !== ex) begin
          n_err++;
          $display("FAIL reset dut%0d got=%h exp=%h", k, got[k], ex);
        end
      end
    end
    n_cmp++;
    if ({sx0, sy0, de0, hs0, vs0, ln0, fr0} !== {10'd799, 10'd524, 5'b01100}) begin
      n_err++;
      $display("FAIL reset_const got sx=%0d sy=%0d exp 799/524", sx0, sy0);
    end
  endtask

  task automatic test_first();
    obs_t ex;
    drive(1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      ex = sbq[k].pop_front();
      n_cmp++;
      if (got[k] !== ex) begin
        n_err++;
        $display("FAIL first_edge dut%0d got=%h exp=%h", k, got[k], ex);
      end
    end
    n_cmp++;
    if ({sx0, sy0, de0, ln0, fr0} !== {20'd0, 3'b111}) begin
      n_err++;
      $display("FAIL first_const got sx=%0d sy=%0d de/line/frame=%b exp 0 0 111",
               sx0, sy0, {de0, ln0, fr0});
    end
  endtask

  task automatic test_line();
    obs_t ex;
    int   last = -1;
    for (int i = 0; i < 1700; i++) begin
      drive(1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        ex = sbq[k].pop_front();
        n_cmp++;
        if (got[k] !== ex) begin
          n_err++;
          $display("FAIL line_run dut%0d got=%h exp=%h", k, got[k], ex);
        end
      end
      if (ln0) begin
        if (last >= 0) begin
          n_cmp++;
          if (i - last != 800) begin
            n_err++;
            $display("FAIL line_period got=%0d exp=800", i - last);
          end
        end
        last = i;
      end
    end
  endtask

  task automatic test_en_hold();
    obs_t ex;
    for (int i = 0; i < 2000 && msx[0] != 655; i++) begin
      drive(1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        ex = sbq[k].pop_front();
        n_cmp++;
        if (got[k] !== ex) begin
          n_err++;
          $display("FAIL hold_approach dut%0d got=%h exp=%h", k, got[k], ex);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, i >= 3);
      for (int k = 0; k < 2; k++) begin
        ex = sbq[k].pop_front();
        n_cmp++;
        if (got[k] !== ex) begin
          n_err++;
          $display("FAIL en_hold dut%0d step%0d got=%h exp=%h", k, i, got[k], ex);
        end
      end
    end
  endtask

  task automatic test_small_frame();
    obs_t ex;
    int   last = -1;
    for (int i = 0; i < 700; i++) begin
      drive(1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        ex = sbq[k].pop_front();
        n_cmp++;
        if (got[k] !== ex) begin
          n_err++;
          $display("FAIL frame_run dut%0d got=%h exp=%h", k, got[k], ex);
        end
      end
      if (fr1) begin
        if (last >= 0) begin
          n_cmp++;
          if (i - last != 208) begin
            n_err++;
            $display("FAIL frame_period got=%0d exp=208", i - last);
          end
        end
        last = i;
      end
    end
  endtask

  task automatic test_en_random();
    obs_t ex;
    for (int i = 0; i < 400; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 2; k++) begin
        ex = sbq[k].pop_front();
        n_cmp++;
        if (got[k] !== ex) begin
          n_err++;
          $display("FAIL en_random dut%0d got=%h exp=%h", k, got[k], ex);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t ex;
    for (int i = 0; i < 2000 && msx[0] != 300; i++) begin
      drive(1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        ex = sbq[k].pop_front();
        n_cmp++;
        if (got[k] !== ex) begin
          n_err++;
          $display("FAIL mid_approach dut%0d got=%h exp=%h", k, got[k], ex);
        end
      end
    end
    for (int i = 0; i < 24; i++) begin
      drive(i == 0, i != 1);
      for (int k = 0; k < 2; k++) begin
        ex = sbq[k].pop_front();
        n_cmp++;
        if (got[k] !== ex) begin
          n_err++;
          $display("FAIL reset_mid dut%0d step%0d got=%h exp=%h", k, i, got[k], ex);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_line();
    test_en_hold();
    test_small_frame();
    test_en_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
